// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } lsu_state_t;

  function automatic logic funct3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: extracts and extends a load result from a memory
// word, and merges sub-word store data into an old word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [3:0][7:0]  lanes;

  assign sel_byte = word[{addr_lo, 3'b000} +: 8];
  assign sel_half = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    rdata = 32'd0;
    case (funct3)
      F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata = {24'd0, sel_byte};
      F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata = {16'd0, sel_half};
      F3_W:    rdata = word;
      default: rdata = 32'd0;
    endcase
  end

  // Each byte lane either takes new store data or keeps the old byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lanes[gi] =
        (funct3 == F3_W)                           ? wdata[8*gi +: 8] :
        (funct3 == F3_H && addr_lo[1] == LANE[1])  ? (LANE[0] ? wdata[15:8] : wdata[7:0]) :
        (funct3 == F3_B && addr_lo == LANE)        ? wdata[7:0] :
                                                     word[8*gi +: 8];
    end
  endgenerate

  assign merged = lanes;

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator: word memory accesses, sub-word stores as
// read-modify-write, sign/zero-extended load results.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state_reg;
  logic [1:0]  addr_lo_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] wdata_reg;
  logic        req_ready_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wd_reg;

  logic [31:0] ext_rdata;
  logic [31:0] merged_word;
  logic        req_err;

  // Halfword alignment applies to both H and HU (funct3[1:0] == 01).
  assign req_err = !funct3_legal(req_funct3)
                 || (req_we && req_funct3[2])
                 || (req_funct3[1:0] == 2'b01 && req_addr[0])
                 || (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
                 || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  lsu_align u_align (
    .word    (mem_rd),
    .wdata   (wdata_reg),
    .addr_lo (addr_lo_reg),
    .funct3  (funct3_reg),
    .rdata   (ext_rdata),
    .merged  (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_lo_reg   <= 2'd0;
      funct3_reg    <= 3'd0;
      wdata_reg     <= 32'd0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wd_reg    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_lo_reg   <= req_addr[1:0];
            funct3_reg    <= req_funct3;
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            if (req_err) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= 32'd0;
            end else begin
              mem_addr_reg <= {2'b00, req_addr[31:2]};
              if (!req_we) begin
                state_reg <= LOAD;
              end else if (req_funct3 == F3_W) begin
                state_reg  <= STORE;
                mem_we_reg <= 1'b1;
                mem_wd_reg <= req_wdata;
              end else begin
                state_reg <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          rsp_rdata_reg <= ext_rdata;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          mem_addr_reg  <= 32'd0;
          state_reg     <= RESP;
        end
        RMW_RD: begin
          // mem_wd_reg doubles as the merge register for the write cycle.
          mem_wd_reg <= merged_word;
          mem_we_reg <= 1'b1;
          state_reg  <= STORE;
        end
        STORE: begin
          mem_we_reg    <= 1'b0;
          mem_wd_reg    <= 32'd0;
          mem_addr_reg  <= 32'd0;
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= 32'd0;
          rsp_err_reg   <= 1'b0;
          state_reg     <= RESP;
        end
        RESP: begin
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= 32'd0;
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wd    = mem_wd_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.DEPTH(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd,
                              input logic exp_err, input int exp_lat, input int exp_nwr,
                              input logic [31:0] exp_wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd;
    v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_nwr = exp_nwr; v.exp_wd = exp_wd;
    return v;
  endfunction

  // Issues one request starting at a negedge; returns at the negedge of the
  // response cycle (or after the cycle budget expires with lat = 0).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic e, output int nwr, output int wcyc,
                        output logic [31:0] wdat, output logic [31:0] wadr);
    int guard;
    lat = 0; rd = 32'hx; e = 1'bx; nwr = 0; wcyc = -1; wdat = 32'h0; wadr = 32'h0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin
        nwr++; wcyc = k; wdat = mem_wd; wadr = mem_addr;
      end
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; e = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    int lat, nwr, wcyc;
    logic [31:0] rd, wdat, wadr;
    logic e;
    int accepts, rsps, last_acc, gap_bad, rd_bad;
    int spurious;

    vecs[0]  = mk(1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF);
    vecs[1]  = mk(0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0);
    vecs[2]  = mk(1, 3'b010, 32'h10,   32'h80FF7F01, 32'h0,        0, 2, 1, 32'h80FF7F01);
    vecs[3]  = mk(0, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0);
    vecs[4]  = mk(0, 3'b100, 32'h13,   32'h0,        32'h00000080, 0, 2, 0, 32'h0);
    vecs[5]  = mk(0, 3'b001, 32'h12,   32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h0);
    vecs[6]  = mk(0, 3'b101, 32'h10,   32'h0,        32'h00007F01, 0, 2, 0, 32'h0);
    vecs[7]  = mk(1, 3'b010, 32'h10,   32'h11223344, 32'h0,        0, 2, 1, 32'h11223344);
    vecs[8]  = mk(1, 3'b000, 32'h11,   32'h000000AB, 32'h0,        0, 3, 1, 32'h1122AB44);
    vecs[9]  = mk(1, 3'b001, 32'h12,   32'h0000CAFE, 32'h0,        0, 3, 1, 32'hCAFEAB44);
    vecs[10] = mk(0, 3'b010, 32'h10,   32'h0,        32'hCAFEAB44, 0, 2, 0, 32'h0);
    vecs[11] = mk(0, 3'b000, 32'h10,   32'h0,        32'h00000044, 0, 2, 0, 32'h0);
    vecs[12] = mk(0, 3'b010, 32'h12,   32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[13] = mk(0, 3'b001, 32'h11,   32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[14] = mk(1, 3'b010, 32'h1000, 32'h12345678, 32'h0,        1, 1, 0, 32'h0);
    vecs[15] = mk(0, 3'b011, 32'h10,   32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[16] = mk(1, 3'b100, 32'h10,   32'h000000FF, 32'h0,        1, 1, 0, 32'h0);

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    rst = 1'b1;
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("reset_mem_we",    {31'd0, mem_we}, 32'd0);
    chk("reset_mem_addr",  mem_addr, 32'd0);
    chk("reset_mem_wd",    mem_wd, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, e, nwr, wcyc, wdat, wadr);
      $display("txn %0d: we=%0d f3=%03b addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0d writes=%0d",
               i, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, e, nwr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_nwrites", i), 32'(nwr), 32'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr > 0) begin
        chk($sformatf("v%0d_write_cycle", i), 32'(wcyc), 32'(vecs[i].exp_lat - 1));
        chk($sformatf("v%0d_write_data", i), wdat, vecs[i].exp_wd);
        chk($sformatf("v%0d_write_addr", i), wadr, {2'b00, vecs[i].addr[31:2]});
      end
    end

    // Continuous LW requests: one accept every 3 cycles over 12 cycles.
    @(negedge clk);
    accepts = 0; rsps = 0; last_acc = -1; gap_bad = 0; rd_bad = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'd0;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) begin
        if (last_acc >= 0 && c - last_acc != 3) gap_bad++;
        last_acc = c;
        accepts++;
      end
      if (rsp_valid) begin
        rsps++;
        if (rsp_rdata !== 32'hCAFEAB44) rd_bad++;
      end
      if (c == 11) req_valid = 1'b0;
      @(negedge clk);
    end
    $display("txn stream: accepts=%0d responses=%0d gap_errors=%0d", accepts, rsps, gap_bad);
    chk("stream_accepts", 32'(accepts), 32'd4);
    chk("stream_responses", 32'(rsps), 32'd4);
    chk("stream_gap_errors", 32'(gap_bad), 32'd0);
    chk("stream_rdata_errors", 32'(rd_bad), 32'd0);

    // Reset asserted while in RMW_RD: no write may be issued.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("txn reset_in_rmw: req_ready=%0d rsp_valid=%0d mem_we=%0d", req_ready, rsp_valid, mem_we);
    chk("rmw_reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rmw_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rmw_reset_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_we || rsp_valid) spurious++;
    end
    chk("rmw_reset_no_activity", 32'(spurious), 32'd0);
    chk("rmw_reset_mem_unchanged", mem[4], 32'hCAFEAB44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
